// File: rtl/dg_stat_upd.sv
// Functional-side updater for the dg_stat status register: accumulates compare-fail
// events and read-modify-writes fl1/nms/cnt (and xen on auto-stop) through the write ports.
module dg_stat_upd #(
    parameter int unsigned BITDATA_CNT = 4,
    parameter int unsigned PEND_W      = 3,
    parameter bit          AUTOSTOP    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   chk_vld,
    input  logic                   chk_fail,
    input  logic                   cwrite,
    input  logic                   dg_stat_fl1_rdat,
    input  logic                   dg_stat_nms_rdat,
    input  logic                   dg_stat_xen_rdat,
    input  logic [BITDATA_CNT-1:0] dg_stat_cnt_rdat,
    output logic                   dg_stat_fl1_wr,
    output logic                   dg_stat_fl1_din,
    output logic                   dg_stat_nms_wr,
    output logic                   dg_stat_nms_din,
    output logic                   dg_stat_xen_wr,
    output logic                   dg_stat_xen_din,
    output logic                   dg_stat_cnt_wr,
    output logic [BITDATA_CNT-1:0] dg_stat_cnt_din,
    output logic                   busy,
    output logic                   pend_ovf
);

    localparam int unsigned SUM_W = BITDATA_CNT + PEND_W;

    localparam logic [BITDATA_CNT-1:0] CNT_ZERO    = {BITDATA_CNT{1'b0}};
    localparam logic [BITDATA_CNT-1:0] CNT_MAX     = {BITDATA_CNT{1'b1}};
    localparam logic [PEND_W-1:0]      PEND_ZERO   = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0]      PEND_ONE    = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0]      PEND_MAX    = {PEND_W{1'b1}};
    localparam logic [SUM_W-1:0]       SUM_CNT_MAX = {{PEND_W{1'b0}}, CNT_MAX};
    localparam logic [SUM_W-1:0]       SUM_NMS_THR = {{(SUM_W-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_SETTLE = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   issue_s;
    logic                   fail_ev_s;
    logic [PEND_W-1:0]      pend_r;
    logic [PEND_W-1:0]      pend_s;
    logic                   pend_ovf_r;
    logic                   pend_ovf_s;
    logic [SUM_W-1:0]       sum_s;
    logic                   stop_s;
    logic                   nms_set_s;
    logic                   busy_r;
    logic                   fl1_wr_r;
    logic                   fl1_din_r;
    logic                   nms_wr_r;
    logic                   nms_din_r;
    logic                   xen_wr_r;
    logic                   xen_din_r;
    logic                   cnt_wr_r;
    logic [BITDATA_CNT-1:0] cnt_din_r;

    // Saturate the widened count back into the register field width.
    function automatic logic [BITDATA_CNT-1:0] clamp_cnt(input logic [SUM_W-1:0] sum);
        logic [BITDATA_CNT-1:0] res;
        if (sum > SUM_CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = sum[BITDATA_CNT-1:0];
        end
        return res;
    endfunction

    assign fail_ev_s = chk_vld & chk_fail & dg_stat_xen_rdat;
    assign sum_s     = {{PEND_W{1'b0}}, dg_stat_cnt_rdat} + {{BITDATA_CNT{1'b0}}, pend_r};
    assign stop_s    = AUTOSTOP && (sum_s >= SUM_CNT_MAX);
    assign nms_set_s = (sum_s >= SUM_NMS_THR);

    // Next-state: CPU writes hold off the update so it always reads settled fields.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((pend_r != PEND_ZERO) && !cwrite) begin
                    state_s = ST_ISSUE;
                    issue_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE:  state_s = ST_SETTLE;
            ST_SETTLE: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Pending accumulator: the issued snapshot is the whole of pend, so only a same-cycle event survives.
    always_comb begin
        pend_s     = pend_r;
        pend_ovf_s = pend_ovf_r;
        if (issue_s) begin
            pend_s = fail_ev_s ? PEND_ONE : PEND_ZERO;
        end else if (fail_ev_s) begin
            if (pend_r == PEND_MAX) begin
                pend_ovf_s = 1'b1;
            end else begin
                pend_s = pend_r + PEND_ONE;
            end
        end else begin
            pend_s = pend_r;
        end
    end

    // State, accumulator and registered write-port outputs; din fields hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            pend_r     <= PEND_ZERO;
            pend_ovf_r <= 1'b0;
            busy_r     <= 1'b0;
            fl1_wr_r   <= 1'b0;
            fl1_din_r  <= 1'b0;
            nms_wr_r   <= 1'b0;
            nms_din_r  <= 1'b0;
            xen_wr_r   <= 1'b0;
            xen_din_r  <= 1'b0;
            cnt_wr_r   <= 1'b0;
            cnt_din_r  <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            pend_r     <= pend_s;
            pend_ovf_r <= pend_ovf_s;
            busy_r     <= (state_s != ST_IDLE) || (pend_s != PEND_ZERO);
            fl1_wr_r   <= issue_s;
            nms_wr_r   <= issue_s;
            cnt_wr_r   <= issue_s;
            xen_wr_r   <= issue_s & stop_s;
            if (issue_s) begin
                fl1_din_r <= 1'b1;
                nms_din_r <= dg_stat_nms_rdat | nms_set_s;
                cnt_din_r <= clamp_cnt(sum_s);
                if (stop_s) begin
                    xen_din_r <= 1'b0;
                end
            end
        end
    end

    assign dg_stat_fl1_wr  = fl1_wr_r;
    assign dg_stat_fl1_din = fl1_din_r;
    assign dg_stat_nms_wr  = nms_wr_r;
    assign dg_stat_nms_din = nms_din_r;
    assign dg_stat_xen_wr  = xen_wr_r;
    assign dg_stat_xen_din = xen_din_r;
    assign dg_stat_cnt_wr  = cnt_wr_r;
    assign dg_stat_cnt_din = cnt_din_r;
    assign busy            = busy_r;
    assign pend_ovf        = pend_ovf_r;

    // fl1 is always set on update; its current value is not needed.
    logic unused_s;
    assign unused_s = dg_stat_fl1_rdat;

endmodule

// File: tb/tb_dg_stat_upd.sv
// Directed bench for dg_stat_upd; a small behavioural dg_stat register model closes the
// read-modify-write loop and lets the bench play the CPU.
module tb_dg_stat_upd;

    logic       clk;
    logic       rst;
    logic       chk_vld;
    logic       chk_fail;
    logic       cpu_we;
    logic       cpu_fl1;
    logic       cpu_nms;
    logic       cpu_xen;
    logic [3:0] cpu_cnt;
    logic       reg_fl1;
    logic       reg_nms;
    logic       reg_xen;
    logic [3:0] reg_cnt;
    logic       fl1_wr, fl1_din, nms_wr, nms_din, xen_wr, xen_din, cnt_wr;
    logic [3:0] cnt_din;
    logic       busy;
    logic       pend_ovf;

    int n_cmp;
    int n_bad;
    int n_pulse;
    int width_err;
    logic prev_wr;
    int base;

    dg_stat_upd #(.BITDATA_CNT(4), .PEND_W(3), .AUTOSTOP(1'b1)) dut (
        .clk(clk), .rst(rst), .chk_vld(chk_vld), .chk_fail(chk_fail), .cwrite(cpu_we),
        .dg_stat_fl1_rdat(reg_fl1), .dg_stat_nms_rdat(reg_nms),
        .dg_stat_xen_rdat(reg_xen), .dg_stat_cnt_rdat(reg_cnt),
        .dg_stat_fl1_wr(fl1_wr), .dg_stat_fl1_din(fl1_din),
        .dg_stat_nms_wr(nms_wr), .dg_stat_nms_din(nms_din),
        .dg_stat_xen_wr(xen_wr), .dg_stat_xen_din(xen_din),
        .dg_stat_cnt_wr(cnt_wr), .dg_stat_cnt_din(cnt_din),
        .busy(busy), .pend_ovf(pend_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register model (CPU write wins) plus pulse counting and width monitoring.
    always @(posedge clk) begin
        if (cpu_we) begin
            reg_fl1 <= cpu_fl1;
            reg_nms <= cpu_nms;
            reg_xen <= cpu_xen;
            reg_cnt <= cpu_cnt;
        end else begin
            if (fl1_wr) reg_fl1 <= fl1_din;
            if (nms_wr) reg_nms <= nms_din;
            if (xen_wr) reg_xen <= xen_din;
            if (cnt_wr) reg_cnt <= cnt_din;
        end
        if (cnt_wr) n_pulse <= n_pulse + 1;
        if (cnt_wr && prev_wr) width_err <= width_err + 1;
        prev_wr <= cnt_wr;
    end

    task automatic cpu_set(input logic [3:0] cnt, input logic xen);
        cpu_we = 1'b1; cpu_cnt = cnt; cpu_xen = xen; cpu_nms = 1'b0; cpu_fl1 = 1'b0;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; chk_vld = 1'b0; chk_fail = 1'b0; cpu_we = 1'b0;
        cpu_cnt = 4'd0; cpu_xen = 1'b0; cpu_nms = 1'b0; cpu_fl1 = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if ({fl1_wr, nms_wr, xen_wr, cnt_wr} !== 4'b0000) begin n_bad++; $display("FAIL reset_wr: got %b want 0000", {fl1_wr, nms_wr, xen_wr, cnt_wr}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (pend_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", pend_ovf); end
        n_cmp++; if ({cnt_din, fl1_din, nms_din, xen_din} !== 7'd0) begin n_bad++; $display("FAIL reset_din: got %h want 0", {cnt_din, fl1_din, nms_din, xen_din}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_fail;
        cpu_set(4'd0, 1'b1);
        base = n_pulse;
        chk_vld = 1'b1; chk_fail = 1'b1;
        @(negedge clk);
        chk_vld = 1'b0; chk_fail = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_early: got %b want 1", busy); end
        n_cmp++; if (cnt_wr !== 1'b0) begin n_bad++; $display("FAIL single_wr_early: got %b want 0", cnt_wr); end
        @(negedge clk);
        n_cmp++; if ({fl1_wr, nms_wr, cnt_wr, xen_wr} !== 4'b1110) begin n_bad++; $display("FAIL single_strobes: got %b want 1110", {fl1_wr, nms_wr, cnt_wr, xen_wr}); end
        n_cmp++; if (cnt_din !== 4'd1) begin n_bad++; $display("FAIL single_cnt_din: got %0d want 1", cnt_din); end
        n_cmp++; if ({fl1_din, nms_din} !== 2'b10) begin n_bad++; $display("FAIL single_fl1_nms: got %b want 10", {fl1_din, nms_din}); end
        @(negedge clk);
        n_cmp++; if ({cnt_wr, busy} !== 2'b01) begin n_bad++; $display("FAIL single_settle: got %b want 01", {cnt_wr, busy}); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_idle: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (n_pulse - base !== 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", n_pulse - base); end
    endtask

    task automatic test_back_to_back;
        cpu_set(4'd14, 1'b1);
        base = n_pulse;
        chk_vld = 1'b1; chk_fail = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (cnt_din !== 4'd15 || cnt_wr !== 1'b1) begin n_bad++; $display("FAIL b2b_cnt: got wr=%b din=%0d want wr=1 din=15", cnt_wr, cnt_din); end
        n_cmp++; if (nms_din !== 1'b1) begin n_bad++; $display("FAIL b2b_nms: got %b want 1", nms_din); end
        n_cmp++; if ({xen_wr, xen_din} !== 2'b10) begin n_bad++; $display("FAIL b2b_xen: got %b want 10", {xen_wr, xen_din}); end
        @(negedge clk);
        chk_vld = 1'b0; chk_fail = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (n_pulse - base !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", n_pulse - base); end
        n_cmp++; if ({reg_cnt, reg_xen, reg_nms, busy} !== {4'd15, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL b2b_final: got cnt=%0d xen=%b nms=%b busy=%b want 15 0 1 0", reg_cnt, reg_xen, reg_nms, busy); end
        chk_vld = 1'b1; chk_fail = 1'b1;
        repeat (2) @(negedge clk);
        chk_vld = 1'b0; chk_fail = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (n_pulse - base !== 2 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stopped: got pulses=%0d busy=%b want 2 0", n_pulse - base, busy); end
    endtask

    task automatic test_xen_off;
        cpu_set(4'd0, 1'b0);
        base = n_pulse;
        chk_vld = 1'b1; chk_fail = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL xen_off_busy%0d: got %b want 0", i, busy); end
        end
        chk_vld = 1'b0; chk_fail = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (n_pulse - base !== 0 || reg_cnt !== 4'd0) begin n_bad++; $display("FAIL xen_off_writes: got pulses=%0d cnt=%0d want 0 0", n_pulse - base, reg_cnt); end
    endtask

    task automatic test_cpu_priority;
        cpu_set(4'd9, 1'b1);
        base = n_pulse;
        cpu_we = 1'b1; cpu_cnt = 4'd0; cpu_xen = 1'b1; cpu_nms = 1'b0; cpu_fl1 = 1'b0;
        @(negedge clk);
        chk_vld = 1'b1; chk_fail = 1'b1;
        repeat (2) @(negedge clk);
        chk_vld = 1'b0; chk_fail = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, cnt_wr} !== 2'b10 || n_pulse != base) begin n_bad++; $display("FAIL cpu_hold: got busy=%b wr=%b pulses=%0d want 1 0 0", busy, cnt_wr, n_pulse - base); end
        n_cmp++; if (reg_cnt !== 4'd0) begin n_bad++; $display("FAIL cpu_clear: got %0d want 0", reg_cnt); end
        cpu_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (cnt_wr !== 1'b1 || cnt_din !== 4'd2) begin n_bad++; $display("FAIL cpu_release_cnt: got wr=%b din=%0d want 1 2", cnt_wr, cnt_din); end
        n_cmp++; if (nms_din !== 1'b1) begin n_bad++; $display("FAIL cpu_release_nms: got %b want 1", nms_din); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || reg_cnt !== 4'd2) begin n_bad++; $display("FAIL cpu_done: got busy=%b cnt=%0d want 0 2", busy, reg_cnt); end
    endtask

    task automatic test_overflow;
        cpu_we = 1'b1; cpu_cnt = 4'd0; cpu_xen = 1'b1; cpu_nms = 1'b0; cpu_fl1 = 1'b0;
        @(negedge clk);
        n_cmp++; if (pend_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_pre: got %b want 0", pend_ovf); end
        chk_vld = 1'b1; chk_fail = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 6) begin
                n_cmp++; if (pend_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_at7: got %b want 0", pend_ovf); end
            end
            if (i == 7) begin
                n_cmp++; if (pend_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_at8: got %b want 1", pend_ovf); end
            end
        end
        chk_vld = 1'b0; chk_fail = 1'b0;
        @(negedge clk);
        n_cmp++; if ({busy, cnt_wr} !== 2'b10) begin n_bad++; $display("FAIL ovf_hold: got %b want 10", {busy, cnt_wr}); end
        cpu_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (cnt_wr !== 1'b1 || cnt_din !== 4'd7) begin n_bad++; $display("FAIL ovf_cnt: got wr=%b din=%0d want 1 7", cnt_wr, cnt_din); end
        n_cmp++; if ({nms_din, xen_wr} !== 2'b10) begin n_bad++; $display("FAIL ovf_nms_xen: got %b want 10", {nms_din, xen_wr}); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({pend_ovf, busy} !== 2'b10) begin n_bad++; $display("FAIL ovf_sticky: got %b want 10", {pend_ovf, busy}); end
    endtask

    task automatic test_reset_mid_issue;
        base = n_pulse;
        chk_vld = 1'b1; chk_fail = 1'b1;
        @(negedge clk);
        n_cmp++; if (cnt_wr !== 1'b0) begin n_bad++; $display("FAIL rmi_pre: got %b want 0", cnt_wr); end
        @(negedge clk);
        n_cmp++; if (cnt_wr !== 1'b1) begin n_bad++; $display("FAIL rmi_issue: got %b want 1", cnt_wr); end
        rst = 1'b0;
        @(negedge clk);
        chk_vld = 1'b0; chk_fail = 1'b0;
        n_cmp++; if ({fl1_wr, nms_wr, cnt_wr, busy, pend_ovf} !== 5'b00000) begin n_bad++; $display("FAIL rmi_drop: got %b want 00000", {fl1_wr, nms_wr, cnt_wr, busy, pend_ovf}); end
        n_cmp++; if (cnt_din !== 4'd0) begin n_bad++; $display("FAIL rmi_din: got %0d want 0", cnt_din); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (n_pulse - base !== 1 || busy !== 1'b0) begin n_bad++; $display("FAIL rmi_discard: got pulses=%0d busy=%b want 1 0", n_pulse - base, busy); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_single_fail;
        test_back_to_back;
        test_xen_off;
        test_cpu_priority;
        test_overflow;
        test_reset_mid_issue;
        n_cmp++; if (width_err !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", width_err); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
